// File: rtl/bank_conflict_scheduler.sv
// Splits one vector of per-lane bank requests into conflict-free grant beats.
// Fixed lane-index priority: the lowest pending lane targeting a bank wins each beat.
module bank_conflict_scheduler #(
    parameter int unsigned N_LANES = 4,
    parameter int unsigned MAP     = 2,
    parameter int unsigned STATW   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_LANES-1:0]     in_mask,
    input  logic [N_LANES*MAP-1:0] in_BI_bus,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_LANES-1:0]     out_grant,
    output logic [N_LANES*MAP-1:0] out_BI_bus,
    output logic [MAP-1:0]         out_round,
    output logic                   out_last,
    output logic [STATW-1:0]       conflict_cnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]             state_q,   state_d;
    logic [N_LANES-1:0]     pending_q, pending_d;
    logic [N_LANES*MAP-1:0] bi_q,      bi_d;
    logic [MAP-1:0]         round_q,   round_d;
    logic [STATW-1:0]       cnt_q,     cnt_d;

    logic [N_LANES-1:0]     grant;
    logic                   blocked;
    logic                   last_beat;

    // A pending lane is held back only by a lower-index pending lane on the same bank.
    always_comb begin
        grant   = '0;
        blocked = 1'b0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < i; j++) begin
                if (pending_q[j] && (bi_q[j*MAP +: MAP] == bi_q[i*MAP +: MAP])) begin
                    blocked = 1'b1;
                end
            end
            grant[i] = pending_q[i] && !blocked;
        end
    end

    assign last_beat = ((pending_q & ~grant) == '0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        bi_d      = bi_q;
        round_d   = round_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                // An all-zero mask is consumed here without producing a beat.
                if (in_valid && (in_mask != '0)) begin
                    bi_d      = in_BI_bus;
                    pending_d = in_mask;
                    round_d   = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    pending_d = pending_q & ~grant;
                    if (last_beat) begin
                        state_d = IDLE;
                        round_d = '0;
                    end else begin
                        round_d = round_q + 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            bi_q      <= '0;
            round_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            bi_q      <= bi_d;
            round_q   <= round_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == ISSUE);
    assign out_grant    = (state_q == ISSUE) ? grant : '0;
    assign out_last     = (state_q == ISSUE) && last_beat;
    assign out_BI_bus   = bi_q;
    assign out_round    = round_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bank_conflict_scheduler.sv
// Scoreboard bench for bank_conflict_scheduler: a per-beat bank-occupancy model
// queues expected beats on acceptance; a negedge monitor pops and compares.
module tb_bank_conflict_scheduler;

    localparam int unsigned N     = 4;
    localparam int unsigned MAP   = 2;
    localparam int unsigned STATW = 16;

    typedef struct {
        logic [N-1:0]     grant;
        logic [MAP-1:0]   round;
        logic             last;
        logic [N*MAP-1:0] bi;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_mask = '0;
    logic [N*MAP-1:0] in_BI_bus = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     out_grant;
    logic [N*MAP-1:0] out_BI_bus;
    logic [MAP-1:0]   out_round;
    logic             out_last;
    logic [STATW-1:0] conflict_cnt;

    beat_t q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned exp_cnt = 0;

    bank_conflict_scheduler #(.N_LANES(N), .MAP(MAP), .STATW(STATW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mask(in_mask), .in_BI_bus(in_BI_bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_grant(out_grant), .out_BI_bus(out_BI_bus),
        .out_round(out_round), .out_last(out_last),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Greedy per-beat model: each bank may be claimed once per beat, lanes scanned low to high.
    task automatic push_vec(input logic [N-1:0] mask, input logic [N*MAP-1:0] bi);
        logic [N-1:0]   pend;
        logic [N-1:0]   g;
        logic [2**MAP-1:0] used;
        logic [MAP-1:0] b;
        beat_t e;
        int unsigned r;
        pend = mask;
        r = 0;
        while (pend != '0) begin
            used = '0;
            g = '0;
            for (int i = 0; i < N; i++) begin
                b = bi[i*MAP +: MAP];
                if (pend[i] && !used[b]) begin
                    g[i] = 1'b1;
                    used[b] = 1'b1;
                end
            end
            e.grant = g;
            e.round = r[MAP-1:0];
            e.last  = ((pend & ~g) == '0);
            e.bi    = bi;
            q.push_back(e);
            pend = pend & ~g;
            r++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 32'(out_grant), 32'(0));
            end else begin
                beat_t e;
                e = q.pop_front();
                check("grant", 32'(out_grant), 32'(e.grant));
                check("round", 32'(out_round), 32'(e.round));
                check("last",  32'(out_last),  32'(e.last));
                check("bi",    32'(out_BI_bus), 32'(e.bi));
                check("cnt",   32'(conflict_cnt), exp_cnt);
                if (!e.last) exp_cnt++;
            end
        end
    end

    task automatic send(input logic [N-1:0] mask, input logic [N*MAP-1:0] bi);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_mask   = mask;
        in_BI_bus = bi;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("in_ready_timeout", 32'(0), 32'(1));
        else push_vec(mask, bi);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) check("drain_timeout", 32'(q.size()), 32'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'(1));
        check("idle_out_valid", 32'(out_valid), 32'(0));
    endtask

    function automatic logic [N*MAP-1:0] mk_bi(input int b0, input int b1, input int b2, input int b3);
        logic [N*MAP-1:0] v;
        v = {MAP'(b3), MAP'(b2), MAP'(b1), MAP'(b0)};
        return v;
    endfunction

    initial begin
        bit ok;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_grant", 32'(out_grant), 32'(0));
        check("rst_bi", 32'(out_BI_bus), 32'(0));
        check("rst_round", 32'(out_round), 32'(0));
        check("rst_last", 32'(out_last), 32'(0));
        check("rst_cnt", 32'(conflict_cnt), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(4'b1111, mk_bi(0, 1, 2, 3));
        drain(1'b0);
        check("cnt_distinct", 32'(conflict_cnt), 32'(0));

        send(4'b1111, mk_bi(2, 2, 2, 2));
        drain(1'b0);
        check("cnt_allsame", 32'(conflict_cnt), 32'(3));

        send(4'b1111, mk_bi(1, 1, 3, 3));
        drain(1'b0);

        out_ready = 1'b0;
        send(4'b1111, mk_bi(1, 1, 3, 3));
        repeat (3) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_grant", 32'(out_grant), 32'(4'b0101));
            check("hold_round", 32'(out_round), 32'(0));
            check("hold_last", 32'(out_last), 32'(0));
            check("hold_in_ready", 32'(in_ready), 32'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain(1'b0);

        send(4'b0000, mk_bi(3, 2, 1, 0));
        @(negedge clk);
        check("zmask_out_valid", 32'(out_valid), 32'(0));
        check("zmask_in_ready", 32'(in_ready), 32'(1));
        send(4'b0110, mk_bi(3, 0, 0, 1));
        drain(1'b0);

        for (int v = 0; v < 20; v++) begin
            send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            drain(1'b1);
        end

        send(4'b1111, mk_bi(2, 2, 2, 2));
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (q.size() == 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("midrst_timeout", 32'(q.size()), 32'(2));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_grant", 32'(out_grant), 32'(0));
        check("midrst_cnt", 32'(conflict_cnt), 32'(0));
        q.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(4'b1111, mk_bi(2, 2, 2, 2));
        drain(1'b0);
        check("post_rst_cnt", 32'(conflict_cnt), 32'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bank_conflict_scheduler.md
Name: bank_conflict_scheduler

Overview:
Sits in front of the lane-to-bank arbiter in the multilane NTT datapath. Accepts one vector of per-lane bank-index requests, which may contain conflicts. Splits the vector over one or more cycles into conflict-free grant beats, so each bank is targeted by at most one lane per beat and the downstream Benes scatter receives only collision-free subsets. Uses fixed lane-index priority and a valid/ready handshake on both sides.

Parameters:
N_LANES, 4, number of lanes (2*P); power of two, >=2
MAP, 2, bank-index width per lane; N_LANES == 2**MAP
STATW, 16, width of saturating conflict-beat counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request vector valid
in_ready  output  1  scheduler can accept a vector
in_mask  input  N_LANES  per-lane request enable, bit i = lane i
in_BI_bus  input  N_LANES*MAP  lane i bank index at [i*MAP +: MAP]
out_valid  output  1  grant beat valid
out_ready  input  1  downstream accepts beat
out_grant  output  N_LANES  lanes issued this beat; banks pairwise distinct
out_BI_bus  output  N_LANES*MAP  latched bank indices of current vector
out_round  output  MAP  beat index within current vector, 0-based
out_last  output  1  final beat of current vector
conflict_cnt  output  STATW  saturating count of accepted non-last beats

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pending=0; BI latch=0; round=0; conflict_cnt=0. Outputs: in_ready=1, out_valid=0, out_grant=0, out_BI_bus=0, out_round=0, out_last=0.
- FSM states: IDLE and ISSUE.
- IDLE:
  - in_ready=1, out_valid=0, out_grant=0, out_last=0.
  - On in_valid&&in_ready with in_mask!=0: latch in_BI_bus, set pending=in_mask, set round=0, go to ISSUE.
  - On in_valid&&in_ready with in_mask==0: vector consumed; no beat is produced; remain in IDLE.
- ISSUE:
  - in_ready=0, out_valid=1.
  - out_grant is derived from registered state: lane i is granted iff pending[i]=1 and no lane j<i has pending[j]=1 with BI[j]==BI[i].
  - out_grant is never 0 while in ISSUE.
  - out_last = ((pending & ~out_grant) == 0).
  - out_BI_bus = latched BI; out_round = round.
- Beat transfer (out_valid&&out_ready):
  - pending <= pending & ~out_grant.
  - If out_last: go to IDLE and set round=0.
  - Otherwise round <= round+1 and conflict_cnt increments, saturating at all-ones.
- Backpressure: while out_ready=0, out_grant, out_BI_bus, out_round and out_last stay stable.
- Latency and throughput:
  - Vector accepted at edge T gives its first beat visible from T+1.
  - A vector needing k beats occupies the block for exactly k cycles at out_ready=1, plus one IDLE acceptance cycle.
  - Peak rate: 1 vector per 2 cycles. This is accepted by design.
- Bounds:
  - Beats per vector are <= the maximum number of requesting lanes sharing one bank, i.e. <= N_LANES.
  - round never exceeds N_LANES-1 and therefore fits in MAP bits.
- Correctness invariants:
  - Every lane with in_mask[i]=1 is granted exactly once per vector.
  - No lane with in_mask[i]=0 is ever granted.
  - Granted lanes in any beat have distinct BI.
- Reset mid-operation aborts the current vector with no further beats. Pending grants are discarded.

Test Plan:
- BI lanes0..3 = 0,1,2,3, mask=1111, out_ready=1 -> one beat: grant=1111, round=0, last=1; conflict_cnt stays 0; in_ready returns high the next cycle.
- BI all =2, mask=1111 -> four beats with grant 0001, 0010, 0100, 1000 and round 0..3; last=1 only on the 4th beat; conflict_cnt=3.
- BI lanes0..3 = 1,1,3,3, mask=1111 -> grant 0101 (round 0, last=0), then 1010 (round 1, last=1).
- Same as the previous case, with out_ready held low for 3 cycles on beat 0 -> grant=0101 and round=0 held stable; beat 1 appears only after the handshake; in_ready stays 0 throughout.
- mask=0000 with in_valid=1 -> accepted, out_valid stays 0, in_ready stays 1. Then mask=0110 with BI lane1=lane2=0 -> beats 0010 then 0100.
- Start the all-bank-2 vector, assert rst_n=0 after beat 1 -> out_valid=0 and in_ready=1 immediately (async). After release, a new vector's first beat has round=0 and conflict_cnt=0.
